// File: rtl/f16_dot_seq.sv
// Sequencer for an external combinational FP16 multiply-accumulate unit.
// Streams (x, y) pairs into the FMAC with z = running accumulator and returns one dot product per start.
module f16_dot_seq #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      acc_init,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [15:0]      in_y,
  output logic [15:0]      fmac_x,
  output logic [15:0]      fmac_y,
  output logic [15:0]      fmac_z,
  input  logic [15:0]      fmac_result,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             err_len
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      x_q, x_d, y_q, y_d, z_q, z_d;
  logic             err_q, err_d;
  logic             len_ok_c;

  assign len_ok_c = (len != '0) && (len <= LEN_W'(MAX_LEN));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok_c) begin
            acc_d   = acc_init;
            cnt_d   = len;
            state_d = FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          z_d     = acc_q;
          state_d = EXEC;
        end
      end
      EXEC: begin
        acc_d   = fmac_result;
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_q == LEN_W'(1)) ? DONE : FETCH;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags decode only the registered state.
  assign in_ready  = (state_q == FETCH);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;
  assign err_len   = err_q;
  assign fmac_x    = x_q;
  assign fmac_y    = y_q;
  assign fmac_z    = z_q;

endmodule

// File: tb/tb_f16_dot_seq.sv
// Bench for f16_dot_seq: behavioural FP16 FMAC on the fmac_* ports, table vectors,
// hand-written corner sequences and randomized integer-valued dot products.
module tb_f16_dot_seq;

  localparam int unsigned LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [15:0]      acc_init;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_x, in_y;
  logic [15:0]      fmac_x, fmac_y, fmac_z, fmac_result;
  logic             busy, out_valid, out_ready, err_len;
  logic [15:0]      out_data;

  int checks = 0;
  int errors = 0;

  f16_dot_seq #(.MAX_LEN(16), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .acc_init(acc_init),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .fmac_x(fmac_x), .fmac_y(fmac_y), .fmac_z(fmac_z), .fmac_result(fmac_result),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) m = real'(h[9:0]) * pow2(-24);
    else        m = real'({1'b1, h[9:0]}) * pow2(e - 25);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    logic s;
    real  a;
    int   e, m;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    if (e > 15) return {s, 5'h1f, 10'h000};
    if (e < -14) begin
      m = $rtoi(a * pow2(e + 24) + 0.5);
      return {s, 15'(m)};
    end
    m = $rtoi(a * 1024.0 + 0.5);
    if (m == 2048) begin m = 1024; e++; end
    if (e > 15) return {s, 5'h1f, 10'h000};
    return {s, 5'(e + 15), 10'(m - 1024)};
  endfunction

  function automatic logic [15:0] i2h(input int v);
    return r2h(real'(v));
  endfunction

  // Stand-in for the external FP16 FMAC: x*y+z, rounded to nearest.
  always_comb fmac_result = r2h(h2r(fmac_x) * h2r(fmac_y) + h2r(fmac_z));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one dot product starting in the current cycle; ends in the IDLE cycle after the handshake.
  task automatic run_dot(input string name, input int n, input int a0,
                         input int xs[16], input int ys[16], input int gap, input int hold,
                         input logic [15:0] exp_out, input int exp_lat);
    int          t, idx, w, part;
    bit          seen, pend;
    logic [15:0] px, py, pz, held;
    start = 1'b1; len = LEN_W'(n); acc_init = i2h(a0);
    in_valid = 1'b0; out_ready = 1'b0;
    t = 0; idx = 0; w = 0; part = a0; seen = 0; pend = 0;
    px = '0; py = '0; pz = '0;
    while (!seen && t < 400) begin
      @(posedge clk); #1;
      t++;
      start = 1'b0; in_valid = 1'b0;
      if (pend) begin
        chk({name, " fmac_x"}, 32'(fmac_x), 32'(px));
        chk({name, " fmac_y"}, 32'(fmac_y), 32'(py));
        chk({name, " fmac_z"}, 32'(fmac_z), 32'(pz));
        chk({name, " exec in_ready"}, 32'(in_ready), 32'(0));
        pend = 0;
      end
      if (out_valid) seen = 1;
      else if (in_ready && idx < n) begin
        if (w < gap) w++;
        else begin
          px = i2h(xs[idx]); py = i2h(ys[idx]); pz = i2h(part);
          in_valid = 1'b1; in_x = px; in_y = py;
          part = part + xs[idx] * ys[idx];
          idx++; w = 0; pend = 1;
        end
      end
    end
    chk({name, " latency"}, seen ? 32'(t) : 32'hffffffff, 32'(exp_lat));
    chk({name, " out_data"}, 32'(out_data), 32'(exp_out));
    if (!seen) return;
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin start = 1'b1; len = LEN_W'(1); end
      @(posedge clk); #1;
      start = 1'b0;
      chk({name, " hold out_valid"}, 32'(out_valid), 32'(1));
      chk({name, " hold out_data"}, 32'(out_data), 32'(held));
      chk({name, " hold busy"}, 32'(busy), 32'(1));
      chk({name, " hold in_ready"}, 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " post out_valid"}, 32'(out_valid), 32'(0));
    chk({name, " post busy"}, 32'(busy), 32'(0));
  endtask

  typedef struct {
    string       name;
    int          n;
    int          a0;
    int          xs[16];
    int          ys[16];
    int          gap;
    int          hold;
    logic [15:0] exp_out;
    int          exp_lat;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int xs[16], ys[16], n, a0, gap, hold, expv;

    rst_n = 1'b0; start = 1'b0; len = '0; acc_init = '0;
    in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset out_valid", 32'(out_valid), 32'(0));
    chk("reset out_data", 32'(out_data), 32'(0));
    chk("reset err_len", 32'(err_len), 32'(0));
    chk("reset fmac_z", 32'(fmac_z), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 16; k++) begin tbl[i].xs[k] = 0; tbl[i].ys[k] = 0; end
      tbl[i].gap = 0; tbl[i].hold = 0; tbl[i].a0 = 0;
    end
    tbl[0].name = "t1_len1"; tbl[0].n = 1; tbl[0].xs[0] = 1; tbl[0].ys[0] = 2;
    tbl[0].exp_out = 16'h4000; tbl[0].exp_lat = 3;
    tbl[1].name = "t2_len3"; tbl[1].n = 3;
    tbl[1].xs[0] = 1; tbl[1].xs[1] = 2; tbl[1].xs[2] = 3;
    tbl[1].ys[0] = 1; tbl[1].ys[1] = 1; tbl[1].ys[2] = 1;
    tbl[1].exp_out = 16'h4600; tbl[1].exp_lat = 7;
    tbl[2] = tbl[1]; tbl[2].name = "t3_gaps"; tbl[2].gap = 2; tbl[2].exp_lat = 13;
    tbl[3].name = "t4_hold"; tbl[3].n = 2; tbl[3].a0 = 5; tbl[3].hold = 5;
    tbl[3].xs[0] = 2; tbl[3].ys[0] = 3; tbl[3].xs[1] = -3; tbl[3].ys[1] = 1;
    tbl[3].exp_out = 16'h4800; tbl[3].exp_lat = 5;
    tbl[4].name = "len16_neg"; tbl[4].n = 16;
    for (int k = 0; k < 16; k++) begin tbl[4].xs[k] = 1; tbl[4].ys[k] = -1; end
    tbl[4].exp_out = 16'hcc00; tbl[4].exp_lat = 33;

    for (int i = 0; i < 5; i++)
      run_dot(tbl[i].name, tbl[i].n, tbl[i].a0, tbl[i].xs, tbl[i].ys,
              tbl[i].gap, tbl[i].hold, tbl[i].exp_out, tbl[i].exp_lat);

    // Illegal lengths: single-cycle err_len, accumulator untouched.
    start = 1'b1; len = LEN_W'(0); acc_init = 16'h1234;
    @(posedge clk); #1; start = 1'b0;
    chk("len0 err_len", 32'(err_len), 32'(1));
    chk("len0 busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    chk("len0 err_len drop", 32'(err_len), 32'(0));
    start = 1'b1; len = LEN_W'(17);
    @(posedge clk); #1; start = 1'b0;
    chk("len17 err_len", 32'(err_len), 32'(1));
    chk("len17 busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    chk("len17 err_len drop", 32'(err_len), 32'(0));
    chk("len17 acc kept", 32'(out_data), 32'(16'hcc00));

    // Reset in the middle of a run.
    start = 1'b1; len = LEN_W'(3); acc_init = 16'h0000;
    @(posedge clk); #1; start = 1'b0;
    in_valid = 1'b1; in_x = 16'h3c00; in_y = 16'h3c00;
    @(posedge clk); #1; in_valid = 1'b0;
    chk("rst exec busy", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst in_ready", 32'(in_ready), 32'(0));
    chk("rst out_valid", 32'(out_valid), 32'(0));
    chk("rst out_data", 32'(out_data), 32'(0));
    chk("rst err_len", 32'(err_len), 32'(0));
    chk("rst fmac_x", 32'(fmac_x), 32'(0));
    chk("rst fmac_z", 32'(fmac_z), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin xs[k] = 0; ys[k] = 0; end
    xs[0] = 3; ys[0] = -2;
    run_dot("after_rst", 1, 1, xs, ys, 0, 0, 16'hc500, 3);

    // Random integer-valued vectors: the dot product is exact in FP16.
    for (int r = 0; r < 25; r++) begin
      n    = int'($urandom_range(16, 1));
      a0   = int'($urandom_range(32)) - 16;
      gap  = int'($urandom_range(2));
      hold = int'($urandom_range(3));
      expv = a0;
      for (int k = 0; k < 16; k++) begin
        xs[k] = int'($urandom_range(8)) - 4;
        ys[k] = int'($urandom_range(8)) - 4;
        if (k < n) expv = expv + xs[k] * ys[k];
      end
      run_dot($sformatf("rand%0d", r), n, a0, xs, ys, gap, hold, i2h(expv), 2 * n + 1 + gap * n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
